// File: rtl/lsu_stall_ctrl.sv
// Load/store unit: turns core B/H/W accesses into word transactions with byte enables and formats load data.
// The issue cycle always stalls the core; the stall is held while mem_ready_i is low, and the transaction is abandoned after WAIT_LIMIT wait cycles.
module lsu_stall_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              core_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cap_we;
    logic [2:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr;
    logic [3:0]        cap_be;
    logic [31:0]       cap_wd;
    logic              issue;
    logic              cnt_inc;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wd;

    function automatic logic access_legal(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0, 3'd4: access_legal = 1'b1;
            3'd1, 3'd5: access_legal = ~off[0];
            3'd2:       access_legal = (off == 2'b00);
            default:    access_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] size, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            3'd0:    load_format = {{24{lane_b[7]}}, lane_b};
            3'd4:    load_format = {24'd0, lane_b};
            3'd1:    load_format = {{16{lane_h[15]}}, lane_h};
            3'd5:    load_format = {16'd0, lane_h};
            default: load_format = word;
        endcase
    endfunction

    // Store lanes are replicated so the memory can pick whichever lane the byte enables select.
    always_comb begin
        fmt_be = 4'b1111;
        fmt_wd = 32'd0;
        if (core_we_i) begin
            case (core_size_i[1:0])
                2'd0: begin
                    fmt_be = 4'b0001 << core_addr_i[1:0];
                    fmt_wd = {4{core_wd_i[7:0]}};
                end
                2'd1: begin
                    fmt_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                    fmt_wd = {2{core_wd_i[15:0]}};
                end
                default: begin
                    fmt_be = 4'b1111;
                    fmt_wd = core_wd_i;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        cnt_inc      = 1'b0;
        core_rd_o    = 32'd0;
        core_stall_o = 1'b0;
        core_err_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'd0;
        mem_addr_o   = '0;
        mem_wd_o     = 32'd0;
        case (state)
            IDLE: begin
                if (core_req_i) begin
                    if (access_legal(core_size_i, core_addr_i[1:0])) begin
                        issue        = 1'b1;
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        mem_we_o     = core_we_i;
                        mem_be_o     = fmt_be;
                        mem_addr_o   = core_addr_i;
                        mem_wd_o     = fmt_wd;
                        state_nxt    = WAIT;
                    end else begin
                        core_err_o = 1'b1;
                    end
                end
            end
            WAIT: begin
                mem_req_o  = 1'b1;
                mem_we_o   = cap_we;
                mem_be_o   = cap_be;
                mem_addr_o = cap_addr;
                mem_wd_o   = cap_wd;
                // A ready arriving in the same cycle as the limit still completes the access.
                if (mem_ready_i) begin
                    core_rd_o = load_format(cap_size, cap_addr[1:0], mem_rd_i);
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
                    core_err_o = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    core_stall_o = 1'b1;
                    cnt_inc      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst_i) begin
            state_nxt    = IDLE;
            issue        = 1'b0;
            cnt_inc      = 1'b0;
            core_rd_o    = 32'd0;
            core_stall_o = 1'b0;
            core_err_o   = 1'b0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            mem_be_o     = 4'd0;
            mem_addr_o   = '0;
            mem_wd_o     = 32'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            cap_we   <= 1'b0;
            cap_size <= 3'd0;
            cap_addr <= '0;
            cap_be   <= 4'd0;
            cap_wd   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                cap_we   <= core_we_i;
                cap_size <= core_size_i;
                cap_addr <= core_addr_i;
                cap_be   <= fmt_be;
                cap_wd   <= fmt_wd;
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_stall_ctrl.sv
// Scoreboard bench for lsu_stall_ctrl: the driver pushes expected outcomes, the monitor pops them as transactions end.
module tb_lsu_stall_ctrl;

    localparam int WAIT_LIMIT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    lsu_stall_ctrl #(.ADDR_W(32), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_err_o(core_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    logic [103:0] all_out;
    assign all_out = {core_rd_o, core_stall_o, core_err_o, mem_req_o, mem_we_o,
                      mem_be_o, mem_addr_o, mem_wd_o};

    // kind: 0 = completed, 1 = rejected as illegal, 2 = timed out
    typedef struct {
        int          kind;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        int          stalls;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] size, input int off, input logic [31:0] w);
        logic [31:0] sh;
        int          v;
        sh = w >> (8 * off);
        case (size)
            3'd0: begin
                v = int'(sh & 32'hFF);
                if (v > 127) v = v - 256;
                return 32'(v);
            end
            3'd4: return sh & 32'hFF;
            3'd1: begin
                v = int'(sh & 32'hFFFF);
                if (v > 32767) v = v - 65536;
                return 32'(v);
            end
            3'd5: return sh & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Reference model plus the per-cycle drive of core and memory sides for one access.
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] word, input int waits,
                             input logic rdy0);
        exp_t e;
        int   nb;
        int   off;
        int   mask;
        int   n;
        bit   legal;
        off   = int'(addr % 4);
        nb    = 1 << (size % 4);
        legal = (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (off % nb == 0);
        e.we   = we;
        e.addr = addr;
        e.kind = !legal ? 1 : (waits > WAIT_LIMIT) ? 2 : 0;
        e.stalls = (e.kind == 2) ? WAIT_LIMIT + 1 : waits + 1;
        if (we) begin
            mask = (1 << nb) - 1;
            e.be = 4'(mask << off);
            e.wd = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        end else begin
            e.be = 4'hF;
            e.wd = 32'd0;
        end
        e.rd = (e.kind == 0) ? ref_load(size, off, word) : 32'd0;
        sbq.push_back(e);

        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = rdy0;
        mem_rd_i    = $urandom;
        if (legal) begin
            n = (waits > WAIT_LIMIT) ? WAIT_LIMIT + 1 : waits;
            for (int i = 0; i < n; i++) begin
                @(posedge clk_i); #1;
                mem_ready_i = 1'b0;
                mem_rd_i    = $urandom;
            end
            if (waits <= WAIT_LIMIT) begin
                @(posedge clk_i); #1;
                mem_ready_i = 1'b1;
                mem_rd_i    = word;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            core_req_i  = 1'b0;
            core_addr_i = $urandom;
            mem_ready_i = ($urandom_range(0, 1) != 0);
            mem_rd_i    = $urandom;
        end
    endtask

    // Monitor state
    bit          in_txn = 1'b0;
    bit          unstable = 1'b0;
    bit          stray = 1'b0;
    bit          prev_stall = 1'b0;
    logic        t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr;
    logic [31:0] t_wd;
    int          n_stall = 0;

    task automatic finish_txn(input int kind);
        exp_t e;
        check("scoreboard_has_entry", 128'(sbq.size() != 0), 128'(1));
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("outcome_kind", 128'(kind), 128'(e.kind));
            check("no_stray_activity", 128'(stray), 128'(0));
            if (e.kind != 1) begin
                check("core_rd", 128'(core_rd_o), 128'(e.rd));
                check("stall_cycles", 128'(n_stall), 128'(e.stalls));
                check("mem_addr", 128'(t_addr), 128'(e.addr));
                check("mem_be", 128'(t_be), 128'(e.be));
                check("mem_wd", 128'(t_wd), 128'(e.wd));
                check("mem_we", 128'(t_we), 128'(e.we));
                check("mem_side_stable", 128'(unstable), 128'(0));
            end
        end
        stray = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            in_txn     = 1'b0;
            prev_stall = 1'b0;
            stray      = 1'b0;
        end else begin
            if (core_stall_o && !mem_req_o) stray = 1'b1;
            if (mem_req_o && !core_stall_o && !prev_stall) stray = 1'b1;
            if (core_rd_o != 32'd0 && !(mem_req_o && !core_stall_o && !core_err_o)) stray = 1'b1;
            if (mem_req_o) begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    t_we     = mem_we_o;
                    t_be     = mem_be_o;
                    t_addr   = mem_addr_o;
                    t_wd     = mem_wd_o;
                    n_stall  = 0;
                    unstable = 1'b0;
                end else if ({mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} != {t_we, t_be, t_addr, t_wd}) begin
                    unstable = 1'b1;
                end
                if (core_stall_o) begin
                    n_stall++;
                end else begin
                    in_txn = 1'b0;
                    finish_txn(core_err_o ? 2 : 0);
                end
            end else if (core_err_o) begin
                finish_txn(1);
            end
            prev_stall = core_stall_o;
        end
    end

    initial begin
        logic [2:0] sz;
        int         r;
        int         waits;
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'd0;
        core_wd_i   = 32'd0;
        mem_rd_i    = 32'd0;
        mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("outputs_during_reset", 128'(all_out), 128'(0));
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;

        do_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        do_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 1'b1);
        do_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 1'b1);
        do_access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80112233, 0, 1'b1);
        do_access(1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 0, 1'b1);
        do_access(1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0, 0, 1'b1);
        do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1'b1);
        do_access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b1);
        do_access(1'b0, 3'd2, 32'h104, 32'h0, 32'h55AA66BB, 3, 1'b1);
        do_access(1'b1, 3'd2, 32'h108, 32'hCAFEF00D, 32'h0, 100, 1'b0);
        do_access(1'b0, 3'd1, 32'h10A, 32'h0, 32'hF00D1234, WAIT_LIMIT, 1'b1);
        idle(1);

        // Reset lands in the first wait cycle of a load.
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h300;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h12345678;
        @(negedge clk_i);
        check("outputs_reset_in_wait", 128'(all_out), 128'(0));
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("outputs_after_reset", 128'(all_out), 128'(0));
        do_access(1'b0, 3'd1, 32'h306, 32'h0, 32'h87654321, 1, 1'b0);

        for (int k = 0; k < 300; k++) begin
            sz = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            waits = (r < 7) ? $urandom_range(0, 3) :
                    (r < 9) ? $urandom_range(4, WAIT_LIMIT) : WAIT_LIMIT + 5;
            do_access(($urandom_range(0, 1) != 0), sz, $urandom, $urandom, $urandom,
                      waits, ($urandom_range(0, 1) != 0));
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("scoreboard_drained", 128'(sbq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
